// File: rtl/decoder_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_rr_arbiter_pkg
//  Description : Shared constants and state encoding for the round-robin
//                arbiter that drives the 2-to-4 select decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_rr_arbiter_pkg;

    // Number of requesters sharing the decoder
    localparam int unsigned c_nreq             = 4;

    // Default grant length limit before an owner is preempted
    localparam int unsigned c_max_hold_default = 8;

    // Controller state encodings
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_grant = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_GRANT = c_st_grant,
        ST_GAP   = c_st_gap
    } state_e;

endpackage
`default_nettype wire

// File: rtl/decoder_rr_arbiter_decoders.sv
`default_nettype none
// ============================================================================
//  Module      : decoders
//  Description : 2-to-4 select decoder with enable. Output is one-hot of sel
//                when en is high, all zeros otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoders (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] dec
);

    // Decode the select into a one-hot line, gated by the enable
    always_comb begin
        dec = 4'b0000;
        if (en) begin
            dec = 4'b0001 << sel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_rr_arbiter
//  Description : Round-robin arbiter/sequencer for the shared 2-to-4 select
//                decoder. Registers the winner onto sel, holds en while the
//                grant lasts, and inserts one dead cycle between owners.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = c_max_hold_default,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_nreq-1:0]   req,
    output logic [1:0]          sel,
    output logic                en,
    output logic [c_nreq-1:0]   gnt,
    output logic                busy,
    output logic                timeout
);

    // Terminal count: an owner still requesting at this count is preempted
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

    state_e             r_state;
    logic [1:0]         r_sel;
    logic               r_en;
    logic               r_busy;
    logic               r_timeout;
    logic [1:0]         r_last;
    logic [CNT_W-1:0]   r_hold_cnt;

    logic               w_any_req;
    logic [1:0]         w_winner;

    // First set request searching upward from last+1 with wrap-around.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [1:0] f_rr_pick(input logic [c_nreq-1:0] rq,
                                             input logic [1:0]        last);
        logic [1:0] idx;
        f_rr_pick = last;
        for (int k = c_nreq; k >= 1; k--) begin
            idx = last + 2'(k);
            if (rq[idx]) begin
                f_rr_pick = idx;
            end
        end
    endfunction

    // Arbitration result, only consumed from IDLE and GAP
    always_comb begin
        w_any_req = |req;
        w_winner  = f_rr_pick(req, r_last);
    end

    // Controller: grant, hold/preempt, forced gap, back to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 2'd0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_last     <= 2'd3;
            r_hold_cnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_any_req) begin
                        r_state    <= ST_GRANT;
                        r_sel      <= w_winner;
                        r_last     <= w_winner;
                        r_en       <= 1'b1;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!req[r_sel]) begin
                        // Release wins over a coincident preemption
                        r_state <= ST_GAP;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (r_hold_cnt == c_hold_last) begin
                        r_state   <= ST_GAP;
                        r_en      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Existing select decoder turns sel/en into the one-hot grant
    decoders u_decoders (
        .sel (r_sel),
        .en  (r_en),
        .dec (gnt)
    );

    assign sel     = r_sel;
    assign en      = r_en;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_rr_arbiter
//  Description : Self-checking bench for decoder_rr_arbiter. Instance a uses
//                MAX_HOLD=8, instance b uses MAX_HOLD=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic [1:0] sel_a, sel_b;
    logic       en_a, en_b, busy_a, busy_b, to_a, to_b;
    logic [3:0] gnt_a, gnt_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .sel(sel_a), .en(en_a),
        .gnt(gnt_a), .busy(busy_a), .timeout(to_a)
    );

    decoder_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .sel(sel_b), .en(en_b),
        .gnt(gnt_b), .busy(busy_b), .timeout(to_b)
    );

    // Reference model: owner (-1 when nobody holds the decoder), whether this
    // cycle is the dead gap, how many cycles the owner has held so far.
    int m_owner [2];
    bit m_gap   [2];
    int m_run   [2];
    int m_last  [2];
    int m_sel   [2];
    bit m_to    [2];
    int mh      [2] = '{8, 1};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_gap[d] = 0; m_run[d] = 0;
            m_last[d]  = 3;  m_sel[d] = 0; m_to[d]  = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r);
        int w;
        m_to[d] = 0;
        if (m_owner[d] >= 0) begin
            if (!r[m_owner[d]]) begin
                m_owner[d] = -1; m_gap[d] = 1;
            end else if (m_run[d] == mh[d]) begin
                m_owner[d] = -1; m_gap[d] = 1; m_to[d] = 1;
            end else begin
                m_run[d]++;
            end
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && r[(m_last[d] + k) % 4]) w = (m_last[d] + k) % 4;
            m_gap[d] = 0;
            if (w >= 0) begin
                m_owner[d] = w; m_last[d] = w; m_sel[d] = w; m_run[d] = 1;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int d);
        return (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
    endfunction

    function automatic logic exp_busy(input int d);
        return (m_owner[d] >= 0) || m_gap[d];
    endfunction

    // One clock: present requests, advance the model, sample 1 ns after edge
    task automatic cyc(input logic [3:0] ra, input logic [3:0] rb);
        req_a = ra; req_b = rb;
        model_step(0, ra); model_step(1, rb);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_a = 4'b0; req_b = 4'b0; rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (gnt_a !== 4'b0 || en_a !== 1'b0 || sel_a !== 2'd0 || busy_a !== 1'b0 || to_a !== 1'b0) begin
            n_err++; $display("FAIL reset_state_a: gnt=%b en=%b sel=%0d busy=%b to=%b expected all zero", gnt_a, en_a, sel_a, busy_a, to_a);
        end
        n_chk++; if (gnt_b !== 4'b0 || busy_b !== 1'b0) begin
            n_err++; $display("FAIL reset_state_b: gnt=%b busy=%b expected 0", gnt_b, busy_b);
        end
        cyc(4'b0100, 4'b0); cyc(4'b0100, 4'b0);
        n_chk++; if (gnt_a !== 4'b0100) begin
            n_err++; $display("FAIL pre_reset_grant: got %b expected 0100", gnt_a);
        end
        #3 rst = 1'b1;
        #1;
        n_chk++; if (gnt_a !== 4'b0 || en_a !== 1'b0 || sel_a !== 2'd0) begin
            n_err++; $display("FAIL async_reset: gnt=%b en=%b sel=%0d expected 0/0/0", gnt_a, en_a, sel_a);
        end
        model_reset();
        #2 rst = 1'b0;
        cyc(4'b0001, 4'b0);
        n_chk++; if (gnt_a !== 4'b0001) begin
            n_err++; $display("FAIL post_reset_grant: got %b expected 0001", gnt_a);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0010, 4'b0);
            n_chk++; if (en_a !== 1'b1 || gnt_a !== 4'b0010 || sel_a !== 2'd1) begin
                n_err++; $display("FAIL single_grant[%0d]: en=%b gnt=%b sel=%0d expected 1/0010/1", i, en_a, gnt_a, sel_a);
            end
        end
        cyc(4'b0, 4'b0);
        n_chk++; if (en_a !== 1'b0 || gnt_a !== 4'b0 || busy_a !== 1'b1 || sel_a !== 2'd1) begin
            n_err++; $display("FAIL single_gap: en=%b gnt=%b busy=%b sel=%0d expected 0/0000/1/1", en_a, gnt_a, busy_a, sel_a);
        end
        cyc(4'b0, 4'b0);
        n_chk++; if (en_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL single_idle: en=%b busy=%b expected 0/0", en_a, busy_a);
        end
    endtask

    task automatic test_rotation();
        int got[$];
        int expect_order[5] = '{0, 1, 2, 3, 0};
        int zero_run;
        logic prev_en;
        logic [3:0] r;
        do_reset();
        zero_run = 0; prev_en = 1'b0;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            r = 4'b1111;
            if (m_owner[0] >= 0 && m_run[0] == 2) r = 4'b1111 & ~(4'b0001 << m_owner[0]);
            cyc(r, 4'b0);
            n_chk++; if (gnt_a !== exp_gnt(0)) begin
                n_err++; $display("FAIL rotation_gnt: got %b expected %b", gnt_a, exp_gnt(0));
            end
            if (en_a && !prev_en) begin
                for (int k = 0; k < 4; k++) if (gnt_a[k]) got.push_back(k);
                if (got.size() > 1) begin
                    n_chk++; if (zero_run != 1) begin
                        n_err++; $display("FAIL rotation_gap: got %0d dead cycles expected 1", zero_run);
                    end
                end
                zero_run = 0;
            end else if (!en_a) begin
                zero_run++;
            end
            prev_en = en_a;
        end
        n_chk++; if (got.size() != 5) begin
            n_err++; $display("FAIL rotation_count: got %0d grants expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++; if (got[i] != expect_order[i]) begin
                    n_err++; $display("FAIL rotation_order[%0d]: got %0d expected %0d", i, got[i], expect_order[i]);
                end
            end
        end
    endtask

    task automatic test_preempt();
        int to_cyc[$];
        int owners[$];
        int want_to[3] = '{9, 18, 27};
        int want_own[3] = '{0, 2, 0};
        logic prev_en;
        do_reset();
        prev_en = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            cyc(4'b0101, 4'b0);
            n_chk++; if (gnt_a !== exp_gnt(0) || to_a !== m_to[0]) begin
                n_err++; $display("FAIL preempt_cycle%0d: gnt=%b to=%b expected %b/%b", c, gnt_a, to_a, exp_gnt(0), m_to[0]);
            end
            if (to_a) to_cyc.push_back(c);
            if (en_a && !prev_en) owners.push_back(int'(sel_a));
            prev_en = en_a;
        end
        n_chk++; if (to_cyc.size() != 3 || owners.size() < 3) begin
            n_err++; $display("FAIL preempt_counts: got %0d timeouts %0d grants expected 3 and >=3", to_cyc.size(), owners.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (to_cyc[i] != want_to[i] || owners[i] != want_own[i]) begin
                    n_err++; $display("FAIL preempt_seq[%0d]: got timeout@%0d owner %0d expected timeout@%0d owner %0d", i, to_cyc[i], owners[i], want_to[i], want_own[i]);
                end
            end
        end
    endtask

    task automatic test_release_at_limit();
        do_reset();
        for (int i = 0; i < 8; i++) cyc(4'b0010, 4'b0);
        n_chk++; if (en_a !== 1'b1 || gnt_a !== 4'b0010) begin
            n_err++; $display("FAIL limit_hold: en=%b gnt=%b expected 1/0010", en_a, gnt_a);
        end
        cyc(4'b0, 4'b0);
        n_chk++; if (en_a !== 1'b0 || to_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++; $display("FAIL release_vs_timeout: en=%b to=%b busy=%b expected 0/0/1", en_a, to_a, busy_a);
        end
    endtask

    task automatic test_max_hold_one();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cyc(4'b0, 4'b1000);
            n_chk++; if (gnt_b !== ((i % 2 == 1) ? 4'b1000 : 4'b0000) || to_b !== (i % 2 == 0)) begin
                n_err++; $display("FAIL maxhold1_cycle%0d: gnt=%b to=%b expected %b/%b", i, gnt_b, to_b, (i % 2 == 1) ? 4'b1000 : 4'b0000, (i % 2 == 0));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ra, rb, pg [2], g [2];
        logic       pe [2], e [2], b [2], t [2];
        logic [1:0] s [2];
        do_reset();
        ra = 4'b0; rb = 4'b0;
        pg[0] = 4'b0; pg[1] = 4'b0; pe[0] = 1'b0; pe[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(3, 0) == 0) ra[k] = ~ra[k];
                if ($urandom_range(3, 0) == 0) rb[k] = ~rb[k];
            end
            cyc(ra, rb);
            g[0] = gnt_a; e[0] = en_a; b[0] = busy_a; t[0] = to_a; s[0] = sel_a;
            g[1] = gnt_b; e[1] = en_b; b[1] = busy_b; t[1] = to_b; s[1] = sel_b;
            for (int d = 0; d < 2; d++) begin
                n_chk++; if (g[d] !== exp_gnt(d) || e[d] !== (m_owner[d] >= 0) || b[d] !== exp_busy(d) || t[d] !== m_to[d] || s[d] !== 2'(m_sel[d])) begin
                    n_err++; $display("FAIL random_d%0d_c%0d: gnt=%b en=%b busy=%b to=%b sel=%0d expected %b/%b/%b/%b/%0d", d, c, g[d], e[d], b[d], t[d], s[d], exp_gnt(d), (m_owner[d] >= 0), exp_busy(d), m_to[d], m_sel[d]);
                end
                n_chk++; if (!$onehot0(g[d]) || (pe[d] && e[d] && g[d] !== pg[d])) begin
                    n_err++; $display("FAIL random_gnt_stable_d%0d_c%0d: gnt=%b prev=%b expected one-hot and unchanged", d, c, g[d], pg[d]);
                end
                pg[d] = g[d]; pe[d] = e[d];
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_a = 4'b0; req_b = 4'b0;
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_release_at_limit();
        test_max_hold_one();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
